// File: rtl/ucisc_pkg.sv
// Shared uCISC definitions: effect codes, flag-register bit positions and
// the store-sequencer state encoding.
package ucisc_pkg;

    localparam int FLAG_W    = 5;
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 3;

    typedef enum logic [2:0] {
        EFF_ZERO     = 3'd0,
        EFF_NOT_ZERO = 3'd1,
        EFF_POSITIVE = 3'd2,
        EFF_ALWAYS   = 3'd3,
        EFF_NOT_NEG  = 3'd4,
        EFF_NEGATIVE = 3'd5,
        EFF_NOT_OVF  = 3'd6,
        EFF_NEVER    = 3'd7
    } effect_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_MEM_WAIT = 2'd2
    } seq_state_e;

    // Only the flag bits the effect decoder looks at.
    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
    } cond_flags_t;

endpackage

// File: rtl/effect_decoder.sv
// Effect decoder: turns an effect code plus the relevant ALU flags into a
// single "perform the store" condition.
module effect_decoder
    import ucisc_pkg::*;
(
    input  effect_e     effect_i,
    input  cond_flags_t flags_i,
    output logic        cond_o
);

    always_comb begin
        // NOTE: default first so every path assigns cond_o and no latch is inferred.
        cond_o = 1'b0;
        case (effect_i)
            EFF_ZERO:     cond_o = flags_i.zero;
            EFF_NOT_ZERO: cond_o = !flags_i.zero;
            EFF_POSITIVE: cond_o = !flags_i.zero && !flags_i.negative;
            EFF_ALWAYS:   cond_o = 1'b1;
            EFF_NOT_NEG:  cond_o = !flags_i.negative;
            EFF_NEGATIVE: cond_o = flags_i.negative;
            EFF_NOT_OVF:  cond_o = !flags_i.overflow;
            EFF_NEVER:    cond_o = 1'b0;
            default:      cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_sequencer.sv
// Store sequencer: conditionally commits an instruction result to the register
// file or to memory. Define STORE_SEQ_TIMEOUT_EN to enable the mem_ack watchdog.
module store_sequencer
    import ucisc_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_effect,
    input  logic              issue_to_mem,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] issue_data,
    input  logic              issue_flags_we,
    input  logic [FLAG_W-1:0] issue_flags,
    output logic [FLAG_W-1:0] flags,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              store_skipped,
    output logic              mem_timeout
);

    seq_state_e        state_q, state_d;
    effect_e           effect_q;
    logic              to_mem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [FLAG_W-1:0] flags_q;
    cond_flags_t       eval_flags_q;

    logic reg_we_q, reg_we_d;
    logic mem_req_q, mem_req_d;
    logic skipped_q, skipped_d;
    logic timeout_q, timeout_d;

    logic accept;
    logic in_eval;
    logic in_wait;
    logic cond_true;
    logic wait_expired;

    assign issue_ready = (state_q == ST_IDLE);
    assign accept      = issue_valid && issue_ready;
    assign in_eval     = (state_q == ST_EVAL);
    assign in_wait     = (state_q == ST_MEM_WAIT);

    // The condition is judged against the flags as they stood before the
    // accepting edge, so snapshot them even when the same edge rewrites flags_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            effect_q     <= EFF_ZERO;
            to_mem_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            flags_q      <= '0;
            eval_flags_q <= '0;
        end else if (accept) begin
            effect_q     <= effect_e'(issue_effect);
            to_mem_q     <= issue_to_mem;
            addr_q       <= issue_addr;
            data_q       <= issue_data;
            eval_flags_q <= '{negative: flags_q[FLAG_NEG],
                              zero:     flags_q[FLAG_ZERO],
                              overflow: flags_q[FLAG_OVF]};
            if (issue_flags_we) begin
                flags_q <= issue_flags;
            end
        end
    end

    effect_decoder u_effect_decoder (
        .effect_i (effect_q),
        .flags_i  (eval_flags_q),
        .cond_o   (cond_true)
    );

`ifdef STORE_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;

    // wait_cnt_q holds the number of MEM_WAIT cycles already completed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (in_wait && !mem_ack) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign wait_expired = in_wait && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wait_expired       = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_EVAL;
            ST_EVAL:     state_d = (cond_true && to_mem_q) ? ST_MEM_WAIT : ST_IDLE;
            ST_MEM_WAIT: if (mem_ack || wait_expired) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // An ack arriving on the final watchdog cycle completes the store normally.
    always_comb begin
        reg_we_d  = 1'b0;
        mem_req_d = 1'b0;
        skipped_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_EVAL: begin
                reg_we_d  = cond_true && !to_mem_q;
                mem_req_d = cond_true && to_mem_q;
                skipped_d = !cond_true;
            end
            ST_MEM_WAIT: begin
                mem_req_d = !(mem_ack || wait_expired);
                timeout_d = wait_expired && !mem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            skipped_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            reg_we_q  <= reg_we_d;
            mem_req_q <= mem_req_d;
            skipped_q <= skipped_d;
            timeout_q <= timeout_d;
        end
    end

    assign flags         = flags_q;
    assign reg_we        = reg_we_q;
    assign reg_addr      = addr_q;
    assign reg_data      = data_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign store_skipped = skipped_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of store data.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning width of store address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the memory-ack watchdog limit (used only under REQ-027).
REQ-004 SHALL have port clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 SHALL have port issue_valid, input, 1 bit, meaning an instruction result is offered.
REQ-007 SHALL have port issue_ready, output, 1 bit, meaning the sequencer accepts an offer this cycle.
REQ-008 SHALL have port issue_effect, input, 3 bits, meaning the effect code (0 zero, 1 not zero, 2 positive, 3 always, 4 not negative, 5 negative, 6 not overflow, 7 never).
REQ-009 SHALL have port issue_to_mem, input, 1 bit, meaning the destination: 1 = memory, 0 = register file.
REQ-010 SHALL have ports issue_addr (input, ADDR_W bits) and issue_data (input, DATA_W bits), meaning the destination address and the result value.
REQ-011 SHALL have ports issue_flags_we (input, 1 bit) and issue_flags (input, 5 bits), meaning the flag-register update request and the new ALU flags.
REQ-012 SHALL have port flags, output, 5 bits, meaning the flag register (bit0 overflow, bit2 zero, bit3 negative).
REQ-013 SHALL have ports reg_we (output, 1 bit), reg_addr (output, ADDR_W bits) and reg_data (output, DATA_W bits), meaning the register-file write strobe and its address and data.
REQ-014 SHALL have ports mem_req (output, 1 bit), mem_addr (output, ADDR_W bits), mem_data (output, DATA_W bits) and mem_ack (input, 1 bit), meaning the memory write handshake.
REQ-015 SHALL have ports store_skipped (output, 1 bit) and mem_timeout (output, 1 bit), meaning one-cycle status pulses.

Function
REQ-016 SHALL implement FSM states IDLE, EVAL and MEM_WAIT; issue_ready SHALL be 1 only in IDLE.
- Accept = issue_valid && issue_ready.
- On accept: latch effect, to_mem, addr and data; go to EVAL.
REQ-017 SHALL evaluate the condition in EVAL against the flag value held before the accepting edge, via the effect decoder.
- Positive = neither zero nor negative.
REQ-018 SHALL, on accept with issue_flags_we=1, load issue_flags into the flag register on that same edge; the evaluation SHALL still use the previous flags.
REQ-019 SHALL, in EVAL with condition false, pulse store_skipped for 1 cycle, assert no write, and return to IDLE.
REQ-020 SHALL, in EVAL with condition true and to_mem=0, pulse reg_we for exactly 1 cycle (accept edge + 1) and return to IDLE.
REQ-021 SHALL, in EVAL with condition true and to_mem=1, assert mem_req from accept edge + 1 and enter MEM_WAIT.
REQ-022 SHALL hold mem_req, mem_addr and mem_data stable in MEM_WAIT until the first cycle mem_ack=1, drop mem_req on the following edge, and return to IDLE.
- Minimum accept-to-accept interval: 2 cycles (register/skip), 3 cycles (memory with immediate ack).
REQ-023 SHALL ignore mem_ack outside MEM_WAIT.
REQ-024 SHALL drive reg_addr/reg_data and mem_addr/mem_data from the latched values at all times.

Reset
REQ-025 SHALL, on reset_n low and regardless of state, immediately set: FSM to IDLE; flags, reg_we, mem_req, store_skipped and mem_timeout to 0; latched addr/data/effect to 0. An in-flight mem_req SHALL be dropped without waiting for ack.
REQ-026 SHALL drive issue_ready=1 on the first cycle after reset_n deasserts.

Configuration
REQ-027 SHALL, with STORE_SEQ_TIMEOUT_EN defined, count cycles in MEM_WAIT from 0. If the count reaches TIMEOUT_CYCLES without ack, it SHALL drop mem_req, pulse mem_timeout for 1 cycle and return to IDLE. An ack on the limit cycle SHALL win.
- Without the macro: no counter; MEM_WAIT waits indefinitely; mem_timeout tied to 0.

Structure
REQ-028 SHALL take the effect-code constants, flag bit indices and FSM state encoding from a shared package (ucisc_pkg).
REQ-029 SHALL instantiate effect_decoder as its single sub-module for condition evaluation.

Verification
REQ-030 SHALL cover: flags=0b00100, effect=0, to_mem=0, data=0x1234 -> reg_we pulse at cycle +1 with reg_data=0x1234.
REQ-031 SHALL cover: flags=0b00100, effect=1 -> store_skipped pulse, no reg_we and no mem_req, issue_ready=1 at cycle +2.
REQ-032 SHALL cover: effect=3, to_mem=1, addr=0x0040, mem_ack delayed 4 cycles -> mem_req high for 5 cycles with stable addr/data, then IDLE.
REQ-033 SHALL cover: flags=0b01000 with issue_flags_we=1, issue_flags=0b00000, effect=5 -> store occurs (old flags used) and flags=0 afterward.
REQ-034 SHALL cover: reset_n pulled low during MEM_WAIT -> mem_req=0 immediately and flags=0.
REQ-035 SHALL cover, with STORE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8: no ack -> mem_timeout pulse after 8 cycles in MEM_WAIT, then issue_ready=1.
